// File: rtl/sipo.sv
// sipo: serial-in parallel-out deserializer feeding a DEPTH-entry valid/ready output FIFO.
// Define SIPO_PARITY_EN to append an even-parity bit to each frame and flag mismatches.
module sipo #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 0,
    parameter int DEPTH     = 2
) (
    input  logic              sclk_i,
    input  logic              rst_n_i,
    input  logic              data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              parity_err_o
);
`ifdef SIPO_PARITY_EN
    localparam int FL = DATA_W + 1;
`else
    localparam int FL = DATA_W;
`endif
    localparam int CW = $clog2(FL);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_SHIFT = 3'b010,
        S_WAIT  = 3'b100
    } state_t;

    state_t              state;
    logic [CW-1:0]       bit_cnt;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   shift_nxt;
    logic [DATA_W-1:0]   push_word;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic                accept;
    logic                last_bit;
    logic                full;
    logic                push;
    logic                pop;

    // Bit positions beyond the data word (the parity slot) leave the word untouched.
    function automatic logic [DATA_W-1:0] insert_bit(input logic [DATA_W-1:0] w,
                                                     input logic [CW-1:0]     idx,
                                                     input logic              b);
        logic [DATA_W-1:0] r;
        r = w;
        for (int i = 0; i < DATA_W; i++) begin
            if (idx == CW'(i)) r[(MSB_FIRST != 0) ? DATA_W - 1 - i : i] = b;
        end
        return r;
    endfunction

    assign ready_o   = (state != S_WAIT);
    assign accept    = valid_i && ready_o;
    assign last_bit  = accept && (bit_cnt == CW'(FL - 1));
    assign full      = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
    assign valid_o   = (rd_ptr != wr_ptr);
    assign pop       = valid_o && ready_i;
    assign shift_nxt = insert_bit(shift_q, bit_cnt, data_i);
    assign push_word = (state == S_WAIT) ? shift_q : shift_nxt;
    assign push      = !full && ((state == S_WAIT) || last_bit);
    assign data_o    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge sclk_i) begin
        if (accept) shift_q <= shift_nxt;
    end

    always_ff @(posedge sclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        bit_cnt <= CW'(1);
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (last_bit) begin
                        bit_cnt <= '0;
                        state   <= full ? S_WAIT : S_IDLE;
                    end else if (accept) begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (!full) state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Push decision uses the registered full flag, so a same-edge pop never bypasses.
    always_ff @(posedge sclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_word;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

`ifdef SIPO_PARITY_EN
    logic par_mismatch;
    logic par_pend_q;

    assign par_mismatch = (^shift_q) != data_i;

    always_ff @(posedge sclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            par_pend_q   <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            if (last_bit) par_pend_q <= par_mismatch;
            parity_err_o <= push && ((state == S_WAIT) ? par_pend_q : par_mismatch);
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: directed scenarios plus randomized traffic against a queue-based model.
module tb_sipo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;
`ifdef SIPO_PARITY_EN
    localparam int FL = DATA_W + 1;
`else
    localparam int FL = DATA_W;
`endif

    logic       sclk    = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       data_i  = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b0;
    logic       ready_o, valid_o, parity_err_o;
    logic [7:0] data_o;
    logic       ready_m, valid_m, perr_m;
    logic [7:0] data_m;

    int checks = 0;
    int errors = 0;

    // Reference model: frame collector plus a bounded queue of finished words.
    int m_q[$];
    int m_word;
    int m_cnt;
    bit m_pend;
    int m_pend_word;
    bit m_pend_err;
    bit m_perr;

    sipo #(.DATA_W(DATA_W), .MSB_FIRST(0), .DEPTH(DEPTH)) dut (
        .sclk_i(sclk), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .parity_err_o(parity_err_o)
    );

    sipo #(.DATA_W(DATA_W), .MSB_FIRST(1), .DEPTH(DEPTH)) dut_m (
        .sclk_i(sclk), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_m), .data_o(data_m), .valid_o(valid_m), .ready_i(ready_i),
        .parity_err_o(perr_m)
    );

    always #5 sclk = ~sclk;

    task automatic model_reset();
        m_q.delete();
        m_word = 0; m_cnt = 0; m_pend = 0; m_pend_word = 0; m_pend_err = 0; m_perr = 0;
    endtask

    task automatic model_step();
        bit full_b, pop, do_push, pe_now;
        int pw;
        bit pe;
        full_b = (m_q.size() == DEPTH);
        pop = (m_q.size() > 0) && ready_i;
        do_push = 0; pw = 0; pe = 0; pe_now = 0;
        if (m_pend) begin
            if (!full_b) begin
                do_push = 1; pw = m_pend_word; pe = m_pend_err; m_pend = 0;
            end
        end else if (valid_i) begin
            if (m_cnt < DATA_W) m_word = m_word + (int'(data_i) << m_cnt);
            else pe_now = (($countones(m_word) % 2) != int'(data_i));
            m_cnt++;
            if (m_cnt == FL) begin
                if (!full_b) begin
                    do_push = 1; pw = m_word; pe = pe_now;
                end else begin
                    m_pend = 1; m_pend_word = m_word; m_pend_err = pe_now;
                end
                m_cnt = 0; m_word = 0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(pw);
        m_perr = do_push && pe;
    endtask

    task automatic tick();
        @(posedge sclk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        valid_i = 0; ready_i = 0; data_i = 0;
        rst_n_i = 0;
        #1;
        model_reset();
        repeat (2) @(posedge sclk);
        #1;
        rst_n_i = 1;
    endtask

    task automatic send_bits(input logic [7:0] w, input bit bad, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            valid_i = 1;
            if (i < DATA_W) data_i = w[i];
            else data_i = bad ? ~(^w) : (^w);
            tick();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({ready_o, valid_o, parity_err_o, data_o} !== 11'b100_0000_0000) begin
            errors++;
            $display("FAIL reset_out: got rdy=%b vld=%b perr=%b data=%h, want 1 0 0 00",
                     ready_o, valid_o, parity_err_o, data_o);
        end
        checks++;
        if ({ready_m, valid_m, perr_m, data_m} !== 11'b100_0000_0000) begin
            errors++;
            $display("FAIL reset_out_msb: got rdy=%b vld=%b perr=%b data=%h, want 1 0 0 00",
                     ready_m, valid_m, perr_m, data_m);
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        ready_i = 1;
        send_bits(8'hA5, 0, 0, FL - 1);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL single_early: valid_o=%b want 0", valid_o);
        end
        send_bits(8'hA5, 0, FL - 1, FL);
        valid_i = 0;
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'hA5 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL single_word: vld=%b data=%h rdy=%b want 1 a5 1", valid_o, data_o, ready_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL single_pop: valid_o=%b want 0", valid_o);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        ready_i = 0;
        send_bits(8'h11, 0, 0, FL);
        send_bits(8'h22, 0, 0, FL);
        send_bits(8'h33, 0, 0, FL);
        valid_i = 0;
        checks++;
        if (valid_o !== 1'b1 || ready_o !== 1'b0 || data_o !== 8'h11) begin
            errors++;
            $display("FAIL bp_wait: vld=%b rdy=%b data=%h want 1 0 11", valid_o, ready_o, data_o);
        end
        ready_i = 1;
        tick();
        checks++;
        if (valid_o !== 1'b1 || ready_o !== 1'b0 || data_o !== 8'h22) begin
            errors++;
            $display("FAIL bp_pop1: vld=%b rdy=%b data=%h want 1 0 22", valid_o, ready_o, data_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || ready_o !== 1'b1 || data_o !== 8'h33) begin
            errors++;
            $display("FAIL bp_pop2: vld=%b rdy=%b data=%h want 1 1 33", valid_o, ready_o, data_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL bp_drain: valid_o=%b want 0", valid_o);
        end
    endtask

    task automatic test_gapped();
        apply_reset();
        ready_i = 0;
        for (int i = 0; i < FL; i++) begin
            send_bits(8'h3C, 0, i, i + 1);
            valid_i = 0;
            data_i = 1'($urandom);
            tick();
            checks++;
            if (i < FL - 1) begin
                if (valid_o !== 1'b0) begin
                    errors++; $display("FAIL gap_spurious: bit %0d valid_o=%b want 0", i, valid_o);
                end
            end else if (valid_o !== 1'b1 || data_o !== 8'h3C) begin
                errors++; $display("FAIL gap_word: vld=%b data=%h want 1 3c", valid_o, data_o);
            end
        end
        ready_i = 1;
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL gap_single: valid_o=%b want 0", valid_o);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ready_i = 1;
        send_bits(8'hFF, 0, 0, 4);
        rst_n_i = 0;
        #1;
        checks++;
        if ({ready_o, valid_o, parity_err_o, data_o} !== 11'b100_0000_0000) begin
            errors++;
            $display("FAIL rstmid_async: rdy=%b vld=%b perr=%b data=%h want 1 0 0 00",
                     ready_o, valid_o, parity_err_o, data_o);
        end
        valid_i = 1; data_i = 1;
        tick();
        checks++;
        if ({ready_o, valid_o, parity_err_o, data_o} !== 11'b100_0000_0000) begin
            errors++;
            $display("FAIL rstmid_hold: rdy=%b vld=%b perr=%b data=%h want 1 0 0 00",
                     ready_o, valid_o, parity_err_o, data_o);
        end
        valid_i = 0;
        model_reset();
        rst_n_i = 1;
        send_bits(8'h0F, 0, 0, FL);
        valid_i = 0;
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h0F) begin
            errors++; $display("FAIL rstmid_word: vld=%b data=%h want 1 0f", valid_o, data_o);
        end
        tick();
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_extra: valid_o=%b want 0", valid_o);
        end
    endtask

    task automatic test_msb_first();
        apply_reset();
        ready_i = 1;
        send_bits(8'h01, 0, 0, FL);
        valid_i = 0;
        checks++;
        if (valid_m !== 1'b1 || data_m !== 8'h80) begin
            errors++; $display("FAIL msb_word: vld=%b data=%h want 1 80", valid_m, data_m);
        end
        checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h01) begin
            errors++; $display("FAIL lsb_word: vld=%b data=%h want 1 01", valid_o, data_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        apply_reset();
        ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            w = 8'($urandom);
            send_bits(w, 0, 0, FL);
            checks++;
            if (valid_o !== 1'b1 || data_o !== w || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL b2b_word%0d: vld=%b rdy=%b data=%h want 1 1 %h", k, valid_o, ready_o, data_o, w);
            end
        end
        valid_i = 0;
    endtask

    task automatic test_parity();
        apply_reset();
        ready_i = 0;
        send_bits(8'hA5, 0, 0, FL);
        valid_i = 0;
        checks++;
        if (parity_err_o !== 1'b0 || data_o !== 8'hA5) begin
            errors++; $display("FAIL par_good: perr=%b data=%h want 0 a5", parity_err_o, data_o);
        end
        ready_i = 1;
        tick();
        ready_i = 0;
        send_bits(8'hA5, 1, 0, FL);
        valid_i = 0;
`ifdef SIPO_PARITY_EN
        checks++;
        if (parity_err_o !== 1'b1 || data_o !== 8'hA5 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL par_bad: perr=%b vld=%b data=%h want 1 1 a5", parity_err_o, valid_o, data_o);
        end
`else
        checks++;
        if (parity_err_o !== 1'b0 || data_o !== 8'hA5) begin
            errors++; $display("FAIL par_tied: perr=%b data=%h want 0 a5", parity_err_o, data_o);
        end
`endif
        tick();
        checks++;
        if (parity_err_o !== 1'b0) begin
            errors++; $display("FAIL par_pulse: perr=%b want 0", parity_err_o);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            valid_i = (($urandom % 4) != 0);
            ready_i = (c < 1000) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            data_i  = 1'($urandom);
            tick();
            checks++;
            if (valid_o !== (m_q.size() > 0)) begin
                errors++; $display("FAIL rnd_valid: cyc %0d got %b want %0d", c, valid_o, m_q.size() > 0);
            end
            checks++;
            if (ready_o !== !m_pend) begin
                errors++; $display("FAIL rnd_ready: cyc %0d got %b want %b", c, ready_o, !m_pend);
            end
            checks++;
            if (parity_err_o !== m_perr) begin
                errors++; $display("FAIL rnd_perr: cyc %0d got %b want %b", c, parity_err_o, m_perr);
            end
            if (m_q.size() > 0) begin
                checks++;
                if (data_o !== 8'(m_q[0])) begin
                    errors++; $display("FAIL rnd_data: cyc %0d got %h want %h", c, data_o, 8'(m_q[0]));
                end
            end
        end
        valid_i = 0;
        ready_i = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        test_msb_first();
        test_back_to_back();
        test_parity();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
